// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
// The state encodings are also used by the stream-mux arbiter, so their
// values must stay fixed.
package demux_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROUTE0 = 2'd1;
  localparam logic [1:0] ST_ROUTE1 = 2'd2;

  // Returns the routing state that a packet bound for the given path enters.
  function automatic logic [1:0] route_state(input logic path);
    return path ? ST_ROUTE1 : ST_ROUTE0;
  endfunction

endpackage

// File: rtl/demux_out_stage.sv
// One-entry output register slice for a valid/ready stream.
// - It loads a beat whenever 'load' is asserted.
// - It holds that beat stable until the consumer takes it.
// - can_load tells the upstream logic that the slot is empty, or that it is
//   draining this cycle, so a new beat can be accepted without a bubble.
module demux_out_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             d_last,
  input  logic             ready_in,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             q_last,
  output logic             can_load
);

  // Capture a new beat on load, otherwise retire the held beat once it is taken.
  always_ff @(posedge clk) begin
    // NOTE: the payload registers are cleared on reset as well as valid,
    // so that a reset leaves the output bus at a known all-zero value.
    // All state in this block uses non-blocking assignments.
    if (rst) begin
      valid  <= 1'b0;
      q      <= '0;
      q_last <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q      <= d;
      q_last <= d_last;
    end else if (ready_in) begin
      valid  <= 1'b0;
    end
  end

  // The slot can take a beat if it is empty, or if its beat leaves this cycle.
  always_comb begin
    can_load = !valid || ready_in;
  end

endmodule

// File: rtl/demux1to2_stream.sv
// 1-to-2 packet demultiplexer. It steers a valid/ready packet stream to one of
// two registered output paths. The route is taken from s on the first beat of
// each packet and is held until that packet's last beat.
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic             busy
);

  logic [1:0] state;
  logic       sel;
  logic       accept;
  logic       load0;
  logic       load1;
  logic       can_load0;
  logic       can_load1;

  // Select the active path: follow s between packets, and the latched route inside a packet.
  always_comb begin
    // NOTE: every signal assigned in this block gets a value on every path.
    // This keeps the logic purely combinational, with no inferred latches.
    sel      = 1'b0;
    in_ready = 1'b0;
    if (state == ST_IDLE) begin
      sel = s;
    end else begin
      sel = (state == ST_ROUTE1);
    end
    // in_ready looks only at the active path, so a stalled idle path never blocks traffic.
    in_ready = !rst && (sel ? can_load1 : can_load0);
  end

  // Steer each accepted beat into the stage of the active path.
  always_comb begin
    accept = in_valid && in_ready;
    load0  = accept && !sel;
    load1  = accept &&  sel;
  end

  // Packet-framing FSM: latch the route on the first beat, release it on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_IDLE:   state <= in_last ? ST_IDLE : route_state(s);
        ST_ROUTE0,
        ST_ROUTE1: state <= in_last ? ST_IDLE : state;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // A packet is in flight whenever the route is latched.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  demux_out_stage #(.WIDTH(WIDTH)) u_stage0 (
    .clk      (clk),
    .rst      (rst),
    .load     (load0),
    .d        (in_data),
    .d_last   (in_last),
    .ready_in (out0_ready),
    .valid    (out0_valid),
    .q        (out0_data),
    .q_last   (out0_last),
    .can_load (can_load0)
  );

  demux_out_stage #(.WIDTH(WIDTH)) u_stage1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load1),
    .d        (in_data),
    .d_last   (in_last),
    .ready_in (out1_ready),
    .valid    (out1_valid),
    .q        (out1_data),
    .q_last   (out1_last),
    .can_load (can_load1)
  );

endmodule
